// File: rtl/rucksack_rom_writer.sv
// rucksack_rom_writer
// Converts a raw day-3 rucksack ASCII stream into the priority-byte memory
// image used by the triple-group summer and writes it through a synchronous
// byte-wide write port starting at address 0.
//   'a'..'z' -> 1..26, 'A'..'Z' -> 27..52, each non-empty line ends with 0x00,
//   and the file ends with one extra 0x00. CR is dropped silently. Empty lines
//   are dropped. Any other byte is dropped and sets err_char.
// Two slots are always reserved for a pad zero and the terminator. An input
// that would overrun them sets err_full and closes the file early.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   start             pulse in IDLE/DONE to begin a conversion at address 0
//   in_valid/in_data/in_last, in_ready   byte stream (in_ready high only in RUN)
//   mem_we/mem_addr/mem_wdata            registered write port, 1-cycle latency
//   busy, done        status (done held until next start or reset)
//   err_char, err_full                   sticky error flags
//   bytes_written, lines                 write count and completed-line count
//   group_err         lines mod 3 != 0 at completion (optional feature)
//
// Optional feature macro: ROM_WRITER_GROUP_CHECK_EN
//   defined   -> mod-3 line tracking drives group_err
//   undefined -> group_err tied to 0
module rucksack_rom_writer #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_char,
  output logic              err_full,
  output logic [ADDR_W:0]   bytes_written,
  output logic [ADDR_W-1:0] lines,
  output logic              group_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_EOL_PAD,
    S_TERM,
    S_DONE
  } state_t;

  // Highest pointer value at which a data/line-end write may still be made.
  localparam logic [ADDR_W:0] WR_LIMIT = (ADDR_W+1)'(DEPTH - 3);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                err_char_q, err_char_d;
  logic                err_full_q, err_full_d;
  logic [ADDR_W-1:0]   lines_q, lines_d;
  logic                open_q, open_d;

  logic                start_ok;
  logic                line_inc;
  logic                need_wr;
  logic                is_eol;
  logic                set_open;
  logic                end_file;
  logic [7:0]          wr_byte;

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_char_d = err_char_q;
    err_full_d = err_full_q;
    lines_d    = lines_q;
    open_d     = open_q;
    line_inc   = 1'b0;
    need_wr    = 1'b0;
    is_eol     = 1'b0;
    set_open   = 1'b0;
    end_file   = 1'b0;
    wr_byte    = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          ptr_d      = '0;
          lines_d    = '0;
          err_char_d = 1'b0;
          err_full_d = 1'b0;
          open_d     = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        if (in_valid) begin
          if (in_data >= 8'h61 && in_data <= 8'h7A) begin
            need_wr  = 1'b1;
            wr_byte  = in_data - 8'h60;
            set_open = 1'b1;
          end else if (in_data >= 8'h41 && in_data <= 8'h5A) begin
            need_wr  = 1'b1;
            wr_byte  = in_data - 8'h26;
            set_open = 1'b1;
          end else if (in_data == 8'h0A) begin
            // An empty line writes nothing, so it can never look like the
            // double zero that terminates the file.
            if (open_q) begin
              need_wr = 1'b1;
              is_eol  = 1'b1;
            end
          end else if (in_data != 8'h0D) begin
            err_char_d = 1'b1;
          end

          end_file = in_last;

          if (need_wr) begin
            if (ptr_q <= WR_LIMIT) begin
              we_d    = 1'b1;
              wdata_d = wr_byte;
              if (set_open) begin
                open_d = 1'b1;
              end
              if (is_eol) begin
                open_d   = 1'b0;
                line_inc = 1'b1;
              end
            end else begin
              // Out of room: close the file as though in_last had arrived.
              err_full_d = 1'b1;
              end_file   = 1'b1;
            end
          end

          if (end_file) begin
            state_d = open_d ? S_EOL_PAD : S_TERM;
          end
        end
      end

      S_EOL_PAD: begin
        we_d     = 1'b1;
        wdata_d  = 8'h00;
        open_d   = 1'b0;
        line_inc = 1'b1;
        state_d  = S_TERM;
      end

      S_TERM: begin
        we_d    = 1'b1;
        wdata_d = 8'h00;
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase

    if (we_d) begin
      addr_d = ptr_q[ADDR_W-1:0];
      ptr_d  = ptr_q + (ADDR_W+1)'(1);
    end
    if (line_inc) begin
      lines_d = lines_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_char_q <= 1'b0;
      err_full_q <= 1'b0;
      lines_q    <= '0;
      open_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_char_q <= err_char_d;
      err_full_q <= err_full_d;
      lines_q    <= lines_d;
      open_q     <= open_d;
    end
  end

`ifdef ROM_WRITER_GROUP_CHECK_EN
  logic [1:0] mod3_q;
  logic       gerr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mod3_q <= '0;
      gerr_q <= 1'b0;
    end else if (start_ok) begin
      mod3_q <= '0;
      gerr_q <= 1'b0;
    end else begin
      if (line_inc) begin
        mod3_q <= (mod3_q == 2'd2) ? 2'd0 : mod3_q + 2'd1;
      end
      // No line can complete in TERM, so mod3_q is final here.
      if (state_q == S_TERM) begin
        gerr_q <= (mod3_q != 2'd0);
      end
    end
  end

  assign group_err = gerr_q;
`else
  assign group_err = 1'b0;
`endif

  // The pointer advances with every write, so it doubles as the write count.
  assign bytes_written = ptr_q;
  assign in_ready      = (state_q == S_RUN);
  assign busy          = (state_q == S_RUN) || (state_q == S_EOL_PAD) || (state_q == S_TERM);
  assign done          = (state_q == S_DONE);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign err_char      = err_char_q;
  assign err_full      = err_full_q;
  assign lines         = lines_q;

endmodule

// File: tb/tb_rucksack_rom_writer.sv
// Directed bench for rucksack_rom_writer. Two instances share the input
// stream: dut_a at default size, dut_b with DEPTH=8 for the capacity case.
// Only the instance that has been started accepts bytes (in_ready is low
// outside RUN). Writes of the selected instance are logged for image checks.
module tb_rucksack_rom_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       sel;

  logic        rdy_a, we_a, busy_a, done_a, ec_a, ef_a, ge_a;
  logic [13:0] addr_a, lines_a;
  logic [7:0]  wd_a;
  logic [14:0] bw_a;

  logic        rdy_b, we_b, busy_b, done_b, ec_b, ef_b, ge_b;
  logic [2:0]  addr_b, lines_b;
  logic [7:0]  wd_b;
  logic [3:0]  bw_b;

  rucksack_rom_writer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(rdy_a), .mem_we(we_a),
    .mem_addr(addr_a), .mem_wdata(wd_a), .busy(busy_a), .done(done_a),
    .err_char(ec_a), .err_full(ef_a), .bytes_written(bw_a), .lines(lines_a),
    .group_err(ge_a)
  );

  rucksack_rom_writer #(.ADDR_W(3), .DEPTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(rdy_b), .mem_we(we_b),
    .mem_addr(addr_b), .mem_wdata(wd_b), .busy(busy_b), .done(done_b),
    .err_char(ec_b), .err_full(ef_b), .bytes_written(bw_b), .lines(lines_b),
    .group_err(ge_b)
  );

  logic        s_rdy, s_we, s_done, s_ec, s_ef, s_ge;
  logic [13:0] s_addr, s_lines;
  logic [7:0]  s_wd;
  logic [14:0] s_bw;

  assign s_rdy   = sel ? rdy_b  : rdy_a;
  assign s_we    = sel ? we_b   : we_a;
  assign s_done  = sel ? done_b : done_a;
  assign s_ec    = sel ? ec_b   : ec_a;
  assign s_ef    = sel ? ef_b   : ef_a;
  assign s_ge    = sel ? ge_b   : ge_a;
  assign s_addr  = sel ? {11'b0, addr_b}  : addr_a;
  assign s_lines = sel ? {11'b0, lines_b} : lines_a;
  assign s_wd    = sel ? wd_b : wd_a;
  assign s_bw    = sel ? {11'b0, bw_b} : bw_a;

  int tests  = 0;
  int failed = 0;

  logic [7:0]  log_d [64];
  logic [13:0] log_a [64];
  int          wcnt = 0;

  always @(posedge clk) begin
    if (s_we && wcnt < 64) begin
      log_d[wcnt] <= s_wd;
      log_a[wcnt] <= s_addr;
      wcnt <= wcnt + 1;
    end
  end

  task automatic do_start(input logic which);
    @(negedge clk);
    sel  = which;
    wcnt = 0;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last, input bit gap);
    int unsigned n = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!s_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!s_rdy) begin
      failed++;
      $display("FAIL send_accept: byte %02h not accepted, in_ready=%0b required 1", b, s_rdy);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (!s_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!s_done) begin
      failed++;
      $display("FAIL wait_done: done=%0b required 1", s_done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({rdy_a, we_a, addr_a, wd_a, busy_a, done_a, ec_a, ef_a, bw_a, lines_a, ge_a} !== '0) begin
      failed++;
      $display("FAIL reset_a: outputs nonzero we=%0b addr=%0h bw=%0d done=%0b required all 0",
               we_a, addr_a, bw_a, done_a);
    end
    tests++;
    if ({rdy_b, we_b, addr_b, wd_b, busy_b, done_b, ec_b, ef_b, bw_b, lines_b, ge_b} !== '0) begin
      failed++;
      $display("FAIL reset_b: outputs nonzero we=%0b addr=%0h bw=%0d done=%0b required all 0",
               we_b, addr_b, bw_b, done_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // "ab\nAZ\n"; with random gaps when gaps=1, image must be unchanged.
  task automatic test_basic(input bit gaps);
    logic [7:0] str [6] = '{8'h61, 8'h62, 8'h0A, 8'h41, 8'h5A, 8'h0A};
    logic [7:0] exp [7] = '{8'h01, 8'h02, 8'h00, 8'h1B, 8'h34, 8'h00, 8'h00};
    do_start(1'b0);
    tests++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      failed++;
      $display("FAIL basic_busy: busy=%0b done=%0b required 1/0", busy_a, done_a);
    end
    for (int i = 0; i < 6; i++) begin
      send(str[i], (i == 5), gaps ? bit'($urandom_range(0, 1)) : 1'b0);
    end
    wait_done();
    tests++;
    if (wcnt !== 7) begin
      failed++;
      $display("FAIL basic_wcnt: got %0d writes required 7", wcnt);
    end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (log_d[i] !== exp[i] || log_a[i] !== 14'(i)) begin
        failed++;
        $display("FAIL basic_image[%0d]: got addr %0d data %02h required addr %0d data %02h",
                 i, log_a[i], log_d[i], i, exp[i]);
      end
    end
    tests++;
    if (bw_a !== 15'd7 || lines_a !== 14'd2 || done_a !== 1'b1 || busy_a !== 1'b0 ||
        ec_a !== 1'b0 || ef_a !== 1'b0) begin
      failed++;
      $display("FAIL basic_status: bw=%0d lines=%0d done=%0b busy=%0b ec=%0b ef=%0b required 7/2/1/0/0/0",
               bw_a, lines_a, done_a, busy_a, ec_a, ef_a);
    end
  endtask

  // "z" with in_last, then a byte held valid during EOL_PAD/TERM.
  task automatic test_eol_pad_hold();
    logic [7:0] exp [3] = '{8'h1A, 8'h00, 8'h00};
    do_start(1'b0);
    send(8'h7A, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h71;
    in_last  = 1'b0;
    tests++;
    if (rdy_a !== 1'b0 || busy_a !== 1'b1) begin
      failed++;
      $display("FAIL hold_eolpad: in_ready=%0b busy=%0b required 0/1", rdy_a, busy_a);
    end
    @(negedge clk);
    tests++;
    if (rdy_a !== 1'b0 || busy_a !== 1'b1) begin
      failed++;
      $display("FAIL hold_term: in_ready=%0b busy=%0b required 0/1", rdy_a, busy_a);
    end
    wait_done();
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (wcnt !== 3 || bw_a !== 15'd3 || lines_a !== 14'd1 || rdy_a !== 1'b0) begin
      failed++;
      $display("FAIL eolpad_status: wcnt=%0d bw=%0d lines=%0d rdy=%0b required 3/3/1/0",
               wcnt, bw_a, lines_a, rdy_a);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (log_d[i] !== exp[i] || log_a[i] !== 14'(i)) begin
        failed++;
        $display("FAIL eolpad_image[%0d]: got addr %0d data %02h required addr %0d data %02h",
                 i, log_a[i], log_d[i], i, exp[i]);
      end
    end
  endtask

  // "a\r\n\nb?\n": CR, empty line and '?' write nothing.
  task automatic test_drops();
    logic [7:0] str [7] = '{8'h61, 8'h0D, 8'h0A, 8'h0A, 8'h62, 8'h3F, 8'h0A};
    logic [7:0] exp [5] = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h00};
    do_start(1'b0);
    for (int i = 0; i < 7; i++) begin
      send(str[i], (i == 6), 1'b0);
    end
    wait_done();
    tests++;
    if (wcnt !== 5 || ec_a !== 1'b1 || ef_a !== 1'b0 || lines_a !== 14'd2 || bw_a !== 15'd5) begin
      failed++;
      $display("FAIL drops_status: wcnt=%0d ec=%0b ef=%0b lines=%0d bw=%0d required 5/1/0/2/5",
               wcnt, ec_a, ef_a, lines_a, bw_a);
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (log_d[i] !== exp[i] || log_a[i] !== 14'(i)) begin
        failed++;
        $display("FAIL drops_image[%0d]: got addr %0d data %02h required addr %0d data %02h",
                 i, log_a[i], log_d[i], i, exp[i]);
      end
    end
  endtask

  // DEPTH=8: seven letters accepted, the seventh overflows; rest never consumed.
  task automatic test_capacity();
    logic [7:0] exp [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    do_start(1'b1);
    for (int i = 0; i < 7; i++) begin
      send(8'(8'h61 + i), 1'b0, 1'b0);
    end
    in_valid = 1'b1;
    in_data  = 8'h68;
    tests++;
    if (rdy_b !== 1'b0) begin
      failed++;
      $display("FAIL cap_ready: in_ready=%0b required 0 after overflow", rdy_b);
    end
    wait_done();
    in_valid = 1'b0;
    tests++;
    if (wcnt !== 8 || bw_b !== 4'd8 || ef_b !== 1'b1 || done_b !== 1'b1 || ec_b !== 1'b0 ||
        lines_b !== 3'd1) begin
      failed++;
      $display("FAIL cap_status: wcnt=%0d bw=%0d ef=%0b done=%0b ec=%0b lines=%0d required 8/8/1/1/0/1",
               wcnt, bw_b, ef_b, done_b, ec_b, lines_b);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (log_d[i] !== exp[i] || log_a[i] !== 14'(i)) begin
        failed++;
        $display("FAIL cap_image[%0d]: got addr %0d data %02h required addr %0d data %02h",
                 i, log_a[i], log_d[i], i, exp[i]);
      end
    end
  endtask

  task automatic test_group(input int nlines);
    logic exp_ge;
`ifdef ROM_WRITER_GROUP_CHECK_EN
    exp_ge = ((nlines % 3) != 0);
`else
    exp_ge = 1'b0;
`endif
    do_start(1'b0);
    for (int i = 0; i < nlines; i++) begin
      send(8'(8'h61 + i), 1'b0, 1'b0);
      send(8'h0A, (i == nlines - 1), 1'b0);
    end
    wait_done();
    tests++;
    if (ge_a !== exp_ge || lines_a !== 14'(nlines) || wcnt !== 2 * nlines + 1) begin
      failed++;
      $display("FAIL group_%0d: group_err=%0b lines=%0d wcnt=%0d required %0b/%0d/%0d",
               nlines, ge_a, lines_a, wcnt, exp_ge, nlines, 2 * nlines + 1);
    end
  endtask

  task automatic test_reset_mid_run();
    int snap;
    do_start(1'b0);
    send(8'h61, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h62;
    rst_n    = 1'b0;
    @(negedge clk);
    tests++;
    if ({rdy_a, we_a, addr_a, wd_a, busy_a, done_a, ec_a, ef_a, bw_a, lines_a, ge_a} !== '0) begin
      failed++;
      $display("FAIL midrun_reset: we=%0b addr=%0h wd=%02h busy=%0b bw=%0d required all 0",
               we_a, addr_a, wd_a, busy_a, bw_a);
    end
    snap = wcnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (wcnt !== snap || busy_a !== 1'b0 || bw_a !== 15'd0) begin
      failed++;
      $display("FAIL midrun_nowrite: writes %0d busy=%0b bw=%0d required %0d/0/0",
               wcnt, busy_a, bw_a, snap);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    sel      = 1'b0;
    test_reset();
    test_basic(1'b0);
    test_eol_pad_hold();
    test_drops();
    test_basic(1'b1);
    test_capacity();
    sel = 1'b0;
    test_group(3);
    test_group(4);
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
